// File: rtl/sound_mixer_pkg.sv
// Shared types, constants and the output saturation helper for the sound mixer.
package sound_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_e;

  localparam int          SAMPLE_WIDTH = 16;
  localparam logic [15:0] OFFSET       = 16'h8000;

  // Clamp a scaled mix to the signed 16-bit range.
  // Returns {clip, sample}; clip is set when the value had to be clamped.
  function automatic logic [16:0] sat16(input logic signed [63:0] acc);
    logic [16:0] r;
    if (acc > 64'sd32767) begin
      r = {1'b1, 16'h7FFF};
    end else if (acc < -64'sd32768) begin
      r = {1'b1, 16'h8000};
    end else begin
      r = {1'b0, acc[15:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/sound_mixer_mac.sv
// Registered signed-sample x unsigned-gain multiply-accumulate.
// A synchronous clear has priority over the accumulate enable.
module mixer_mac
  import sound_mixer_pkg::*;
#(
  parameter int GAIN_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  input  logic        [GAIN_W-1:0]       gain_i,
  output logic signed [ACC_W-1:0]        acc_o
);

  // Product of a 16-bit signed sample and a zero-extended gain needs 17+GAIN_W bits.
  localparam int PROD_W = SAMPLE_WIDTH + 1 + GAIN_W;

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  assign sample_ext = {{(PROD_W-SAMPLE_WIDTH){sample_i[SAMPLE_WIDTH-1]}}, sample_i};
  assign gain_ext   = {{(PROD_W-GAIN_W){1'b0}}, gain_i};
  assign prod       = sample_ext * gain_ext;

  // Next accumulator value: clear wins, then accumulate, else hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sound_mixer.sv
// Time-multiplexed audio mixer: snapshots all channels on the sample strobe,
// accumulates gain-weighted samples one channel per clock through a shared MAC,
// then scales, saturates and presents the result as signed and offset-binary.
module sound_mixer
  import sound_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int GAIN_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 I_RSTn,
  input  logic                                 audio_clk_en,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_samples,
  input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0]   gains,
  output logic signed [SAMPLE_WIDTH-1:0]       out,
  output logic [SAMPLE_WIDTH-1:0]              O_SOUND_DAT,
  output logic                                 out_valid,
  output logic                                 clip,
  output logic                                 overrun
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  // Wide enough that NUM_CHANNELS full-scale products can never overflow.
  localparam int ACC_W = SAMPLE_WIDTH + 1 + GAIN_WIDTH + $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic signed [SAMPLE_WIDTH-1:0]  samp_q [NUM_CHANNELS];
  logic [GAIN_WIDTH-1:0]           gain_q [NUM_CHANNELS];

  logic                            snap_en;
  logic                            mac_clr;
  logic                            mac_en;
  logic                            out_ld;

  logic signed [ACC_W-1:0]         acc;
  logic signed [ACC_W-1:0]         scaled;
  logic [16:0]                     sat_res;

  logic signed [SAMPLE_WIDTH-1:0]  out_q, out_d;
  logic                            out_valid_q;
  logic                            clip_q;
  logic                            overrun_q;

  // Next-state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_en = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    out_ld  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          snap_en = 1'b1;
          mac_clr = 1'b1;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        mac_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCALE: begin
        out_ld  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and channel index registers.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot of every channel's sample and gain, taken on the accepted strobe.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        samp_q[k] <= '0;
        gain_q[k] <= '0;
      end
    end else if (snap_en) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        samp_q[k] <= in_samples[SAMPLE_WIDTH*k +: SAMPLE_WIDTH];
        gain_q[k] <= gains[GAIN_WIDTH*k +: GAIN_WIDTH];
      end
    end
  end

  mixer_mac #(
    .GAIN_W (GAIN_WIDTH),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (I_RSTn),
    .clr_i    (mac_clr),
    .en_i     (mac_en),
    .sample_i (samp_q[idx_q]),
    .gain_i   (gain_q[idx_q]),
    .acc_o    (acc)
  );

  // Divide out unity gain; the arithmetic shift floors toward minus infinity.
  assign scaled  = acc >>> (GAIN_WIDTH - 1);
  assign sat_res = sat16({{(64-ACC_W){scaled[ACC_W-1]}}, scaled});
  assign out_d   = sat_res[15:0];

  // Output sample register: loads once per mix, holds otherwise.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      out_q <= '0;
    end else if (out_ld) begin
      out_q <= out_d;
    end
  end

  // Single-cycle status pulses; a strobe seen while busy is dropped and flagged.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_ld;
      clip_q      <= out_ld & sat_res[16];
      overrun_q   <= audio_clk_en & (state_q != IDLE);
    end
  end

  assign out         = out_q;
  assign O_SOUND_DAT = out_q ^ OFFSET;
  assign out_valid   = out_valid_q;
  assign clip        = clip_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Bench for sound_mixer: table of vectors plus hand-written reset/overrun sequences,
// expected results queued at strobe time and matched when out_valid appears.
module tb_sound_mixer;

  localparam int N  = 4;
  localparam int GW = 8;

  logic                   clk = 1'b0;
  logic                   I_RSTn;
  logic                   audio_clk_en;
  logic [N*16-1:0]        in_samples;
  logic [N*GW-1:0]        gains;
  logic signed [15:0]     out;
  logic [15:0]            O_SOUND_DAT;
  logic                   out_valid;
  logic                   clip;
  logic                   overrun;

  always #5 clk = ~clk;

  sound_mixer #(
    .NUM_CHANNELS (N),
    .GAIN_WIDTH   (GW)
  ) dut (
    .clk          (clk),
    .I_RSTn       (I_RSTn),
    .audio_clk_en (audio_clk_en),
    .in_samples   (in_samples),
    .gains        (gains),
    .out          (out),
    .O_SOUND_DAT  (O_SOUND_DAT),
    .out_valid    (out_valid),
    .clip         (clip),
    .overrun      (overrun)
  );

  typedef struct packed {
    logic [N-1:0][15:0]   s;
    logic [N-1:0][GW-1:0] g;
    logic signed [15:0]   eo;
    logic                 ec;
  } vec_t;

  typedef struct {
    logic signed [15:0] eo;
    logic               ec;
    int                 cyc;
  } exp_t;

  exp_t               sb[$];
  int                 tests   = 0;
  int                 fails   = 0;
  int                 cyc     = 0;
  int                 ovr_cnt = 0;
  logic signed [15:0] last_out = 16'sd0;
  vec_t               vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample outputs on the falling edge, then advance past the next rising edge.
  task automatic cycle();
    exp_t        e;
    logic [15:0] exp_sd;
    @(negedge clk);
    if (overrun) ovr_cnt++;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e      = sb.pop_front();
        exp_sd = e.eo ^ 16'h8000;
        chk("out", out, e.eo);
        chk("sound_dat", O_SOUND_DAT, exp_sd);
        chk("clip", clip, e.ec);
        chk("latency", cyc, e.cyc);
      end
      last_out = out;
    end else begin
      if (clip) chk("clip_without_valid", 1, 0);
      if (!I_RSTn) last_out = 16'sd0;
      else if (out != last_out) chk("out_hold", out, last_out);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic strobe(input vec_t v, input bit expect_out);
    exp_t e;
    in_samples   = v.s;
    gains        = v.g;
    audio_clk_en = 1'b1;
    if (expect_out) begin
      e.eo  = v.eo;
      e.ec  = v.ec;
      e.cyc = cyc + N + 2;
      sb.push_back(e);
    end
    cycle();
    audio_clk_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      cycle();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int g0, input int g1, input int g2, input int g3,
                              input int eo, input bit ec);
    vec_t v;
    v.s[0] = 16'(s0); v.s[1] = 16'(s1); v.s[2] = 16'(s2); v.s[3] = 16'(s3);
    v.g[0] = GW'(g0); v.g[1] = GW'(g1); v.g[2] = GW'(g2); v.g[3] = GW'(g3);
    v.eo   = 16'(eo);
    v.ec   = ec;
    return v;
  endfunction

  // Reference mix: exact integer sum, floor division by unity gain, clamp.
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    longint acc = 0;
    for (int k = 0; k < N; k++) begin
      acc += longint'($signed(v.s[k])) * longint'(v.g[k]);
    end
    acc = acc >>> (GW - 1);
    if (acc > 32767) begin
      r.eo = 16'sh7FFF; r.ec = 1'b1;
    end else if (acc < -32768) begin
      r.eo = 16'sh8000; r.ec = 1'b1;
    end else begin
      r.eo = 16'(acc); r.ec = 1'b0;
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;

    // Reset held with a strobe present: nothing may happen.
    I_RSTn       = 1'b0;
    audio_clk_en = 1'b1;
    in_samples   = {16'd1, 16'd2, 16'd3, 16'd1000};
    gains        = {8'd128, 8'd128, 8'd128, 8'd128};
    repeat (4) cycle();
    chk("rst_out", out, 0);
    chk("rst_sound_dat", O_SOUND_DAT, 32'h8000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    audio_clk_en = 1'b0;
    I_RSTn       = 1'b1;
    repeat (8) cycle();
    chk("post_rst_out", out, 0);
    chk("post_rst_sound_dat", O_SOUND_DAT, 32'h8000);

    //            s0      s1    s2    s3     g0   g1  g2   g3   out     clip
    vecs[0]  = mk(1000,   0,    0,    0,     128, 0,  0,   0,   1000,   0);
    vecs[1]  = mk(-1,     300,  0,    0,     64,  64, 0,   0,   149,    0);
    vecs[2]  = mk(-1,     0,    0,    0,     64,  0,  0,   0,   -1,     0);
    vecs[3]  = mk(30000,  30000,30000,30000, 128, 128,128, 128, 32767,  1);
    vecs[4]  = mk(-32768, 7,    7,    7,     255, 0,  0,   0,   -32768, 1);
    vecs[5]  = mk(32767,  0,    0,    0,     128, 0,  0,   0,   32767,  0);
    vecs[6]  = mk(-32768, 0,    0,    0,     128, 0,  0,   0,   -32768, 0);
    vecs[7]  = mk(100,    -200, 300,  -400,  128, 64, 32,  255, -722,   0);
    vecs[8]  = mk(5000,   5000, 5000, 5000,  0,   0,  0,   0,   0,      0);
    vecs[9]  = mk(32767,  1,    0,    0,     128, 128,0,   0,   32767,  1);
    vecs[10] = mk(-32768, -1,   0,    0,     128, 128,0,   0,   -32768, 1);
    vecs[11] = mk(0,      0,    0,    -3,    0,   0,  0,   1,   -1,     0);

    for (int i = 0; i < 12; i++) begin
      strobe(vecs[i], 1'b1);
      repeat (7) cycle();
    end
    drain();

    // Randomised mixes checked against the reference model.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) begin
        v.s[k] = 16'($urandom);
        v.g[k] = GW'($urandom_range(0, 255));
      end
      v = model(v);
      strobe(v, 1'b1);
      repeat (7) cycle();
    end
    drain();
    chk("no_overrun_yet", ovr_cnt, 0);

    // Second strobe two cycles into a mix is dropped; result is the first snapshot.
    strobe(mk(1000, 0, 0, 0, 128, 0, 0, 0, 1000, 0), 1'b1);
    cycle();
    strobe(mk(-5000, -5000, 0, 0, 128, 128, 0, 0, 0, 0), 1'b0);
    repeat (10) cycle();
    drain();
    chk("overrun_count", ovr_cnt, 1);
    chk("overrun_result", out, 1000);

    // Reset in the middle of accumulation aborts the mix.
    strobe(mk(2000, 0, 0, 0, 128, 0, 0, 0, 2000, 0), 1'b0);
    cycle();
    cycle();
    I_RSTn = 1'b0;
    cycle();
    cycle();
    chk("midrst_out", out, 0);
    chk("midrst_sound_dat", O_SOUND_DAT, 32'h8000);
    // Release coincident with a strobe: accepted on the first active edge.
    I_RSTn = 1'b1;
    strobe(mk(2000, -1234, 0, 0, 0, 128, 0, 0, -1234, 0), 1'b1);
    repeat (8) cycle();
    drain();
    chk("final_overrun_count", ovr_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
